// File: rtl/rf_bank.sv
// rtl/rf_bank.sv - banked GPR file (R0-R7 banked, R8-R15 shared) with in-order load scoreboard
// Optional feature: define RF_BYPASS_EN to forward same-cycle EX/MA write data to the read ports.
module rf_bank #(
    parameter int NRD   = 3,
    parameter int NBANK = 2,
    parameter int LDQ   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [4*NRD-1:0]           rd_idx,
    output logic [32*NRD-1:0]          rd_data,
    output logic [NRD-1:0]             busy,
    input  logic                       ex_we,
    input  logic [3:0]                 ex_idx,
    input  logic [31:0]                ex_data,
    input  logic                       ld_issue,
    input  logic [3:0]                 ld_idx,
    input  logic                       ma_we,
    input  logic [31:0]                ma_data,
    input  logic                       bank_push,
    input  logic                       bank_pop,
    output logic [$clog2(NBANK)-1:0]   bank_cur,
    output logic                       bank_ovf,
    output logic                       ldq_full,
    output logic                       ld_err
);
    localparam int BW    = $clog2(NBANK);
    localparam int NPHYS = 8 * NBANK + 8;
    localparam int PW    = $clog2(NPHYS);
    localparam int QW    = (LDQ > 1) ? $clog2(LDQ) : 1;
    localparam int CW    = $clog2(LDQ + 1);

    logic [31:0]   regs_q [NPHYS];
    logic [31:0]   regs_d [NPHYS];
    logic [PW-1:0] ldq_q  [LDQ];
    logic [PW-1:0] ldq_d  [LDQ];
    logic [QW-1:0] head_q, head_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bank_q, bank_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic             q_full, q_empty;
    logic             ex_wr, ma_ok, iss_try, iss_ok;
    logic [PW-1:0]    head_phys, ex_phys, rp;
    logic [NPHYS-1:0] pend;

    // Banked registers live at bank*8+n; the shared R8-R15 sit above all banks.
    function automatic logic [PW-1:0] phys(input logic [3:0] idx, input logic [BW-1:0] bank);
        if (idx[3]) return PW'(8 * NBANK) + PW'(idx[2:0]);
        return PW'({bank, idx[2:0]});
    endfunction

    // Modulo-LDQ pointer add; operands never exceed 2*LDQ-1.
    function automatic logic [QW-1:0] qadd(input logic [QW-1:0] a, input int b);
        int t;
        t = int'(a) + b;
        if (t >= LDQ) t = t - LDQ;
        return QW'(t);
    endfunction

    assign q_full    = (cnt_q == CW'(LDQ));
    assign q_empty   = (cnt_q == '0);
    assign ex_wr     = ex_we && !stall && !rst;
    assign ma_ok     = ma_we && !q_empty && !rst;
    assign iss_try   = ld_issue && !stall;
    assign iss_ok    = iss_try && !q_full && !rst;
    assign head_phys = ldq_q[head_q];
    assign ex_phys   = phys(ex_idx, bank_q);

    assign bank_cur = bank_q;
    assign bank_ovf = ovf_q;
    assign ldq_full = q_full;
    assign ld_err   = err_q;

    // Pending set is derived from queue contents, so duplicate targets stay pending until the last one returns.
    always_comb begin
        pend = '0;
        for (int i = 0; i < LDQ; i++) begin
            if (i < int'(cnt_q)) pend[ldq_q[qadd(head_q, i)]] = 1'b1;
        end
    end

`ifdef RF_BYPASS_EN
    logic [NPHYS-1:0] pend_rest;

    // Pending set excluding the head entry: what remains after this cycle's load return.
    always_comb begin
        pend_rest = '0;
        for (int i = 1; i < LDQ; i++) begin
            if (i < int'(cnt_q)) pend_rest[ldq_q[qadd(head_q, i)]] = 1'b1;
        end
    end
`endif

    // Next-state: MA write then EX write (EX wins), queue push/pop, bank stack, sticky errors.
    always_comb begin
        regs_d = regs_q;
        ldq_d  = ldq_q;
        head_d = head_q;
        cnt_d  = cnt_q + CW'(iss_ok) - CW'(ma_ok);
        bank_d = bank_q;
        ovf_d  = ovf_q;
        err_d  = err_q | (iss_try && q_full) | (ma_we && q_empty);
        if (ma_ok) begin
            regs_d[head_phys] = ma_data;
            head_d            = qadd(head_q, 1);
        end
        if (ex_wr) regs_d[ex_phys] = ex_data;
        if (iss_ok) ldq_d[qadd(head_q, int'(cnt_q))] = phys(ld_idx, bank_q);
        if (!stall && bank_push && !bank_pop) begin
            if (bank_q == BW'(NBANK - 1)) ovf_d = 1'b1;
            else                          bank_d = bank_q + BW'(1);
        end
        if (!stall && bank_pop && !bank_push && bank_q != '0) bank_d = bank_q - BW'(1);
        if (rst) begin
            head_d = '0;
            cnt_d  = '0;
            bank_d = '0;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end
    end

    // Read ports and per-port load-pending flags.
    always_comb begin
        rd_data = '0;
        busy    = '0;
        rp      = '0;
        for (int p = 0; p < NRD; p++) begin
            rp                  = phys(rd_idx[4*p +: 4], bank_q);
            rd_data[32*p +: 32] = regs_q[rp];
            busy[p]             = pend[rp];
`ifdef RF_BYPASS_EN
            if (ma_ok && head_phys == rp) begin
                rd_data[32*p +: 32] = ma_data;
                busy[p]             = pend_rest[rp];
            end
            if (ex_wr && ex_phys == rp) rd_data[32*p +: 32] = ex_data;
`endif
        end
    end

    // State registers; reset is folded into the _d logic, GPR contents are never reset.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        ldq_q  <= ldq_d;
        head_q <= head_d;
        cnt_q  <= cnt_d;
        bank_q <= bank_d;
        ovf_q  <= ovf_d;
        err_q  <= err_d;
    end
endmodule

// File: tb/tb_rf_bank.sv
// tb/tb_rf_bank.sv - directed and random checks of rf_bank against a keyed-register/queue model
module tb_rf_bank;
    localparam int NRD   = 3;
    localparam int NBANK = 2;
    localparam int LDQ   = 2;

    logic              clk = 1'b0;
    logic              rst, stall;
    logic [4*NRD-1:0]  rd_idx;
    logic [32*NRD-1:0] rd_data;
    logic [NRD-1:0]    busy;
    logic              ex_we;
    logic [3:0]        ex_idx;
    logic [31:0]       ex_data;
    logic              ld_issue;
    logic [3:0]        ld_idx;
    logic              ma_we;
    logic [31:0]       ma_data;
    logic              bank_push, bank_pop;
    logic [0:0]        bank_cur;
    logic              bank_ovf, ldq_full, ld_err;

    rf_bank #(.NRD(NRD), .NBANK(NBANK), .LDQ(LDQ)) dut (
        .clk(clk), .rst(rst), .stall(stall), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy),
        .ex_we(ex_we), .ex_idx(ex_idx), .ex_data(ex_data),
        .ld_issue(ld_issue), .ld_idx(ld_idx), .ma_we(ma_we), .ma_data(ma_data),
        .bank_push(bank_push), .bank_pop(bank_pop), .bank_cur(bank_cur), .bank_ovf(bank_ovf),
        .ldq_full(ldq_full), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mreg [int];
    int          mq [$];
    int          mbank = 0;
    logic        movf = 1'b0;
    logic        merr = 1'b0;
    int          total = 0;
    int          bad = 0;

    // Registers are keyed by location: banked ones by bank and number, shared ones in their own range.
    function automatic int key(input logic [3:0] idx, input int b);
        if (idx[3]) return 100 + int'(idx[2:0]);
        return b * 8 + int'(idx[2:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; stall = 0; ex_we = 0; ex_idx = 0; ex_data = 0;
        ld_issue = 0; ld_idx = 0; ma_we = 0; ma_data = 0; bank_push = 0; bank_pop = 0;
    endtask

    task automatic compare_outputs();
        for (int p = 0; p < NRD; p++) begin
            int          k;
            int          c;
            logic        known;
            logic [31:0] ev;
            k     = key(rd_idx[4*p +: 4], mbank);
            known = mreg.exists(k);
            ev    = known ? mreg[k] : 32'h0;
            c     = 0;
            foreach (mq[i]) if (mq[i] == k) c++;
`ifdef RF_BYPASS_EN
            if (!rst && ma_we && mq.size() > 0 && mq[0] == k) begin
                ev = ma_data; known = 1'b1; c--;
            end
            if (!rst && ex_we && !stall && key(ex_idx, mbank) == k) begin
                ev = ex_data; known = 1'b1;
            end
`endif
            if (known) check($sformatf("rd_data[%0d]", p), rd_data[32*p +: 32], ev);
            check($sformatf("busy[%0d]", p), {31'b0, busy[p]}, (c > 0) ? 32'd1 : 32'd0);
        end
        check("bank_cur", {31'b0, bank_cur}, mbank);
        check("bank_ovf", {31'b0, bank_ovf}, {31'b0, movf});
        check("ldq_full", {31'b0, ldq_full}, (mq.size() == LDQ) ? 32'd1 : 32'd0);
        check("ld_err", {31'b0, ld_err}, {31'b0, merr});
    endtask

    task automatic model_update();
        int   b;
        int   k;
        logic full0, empty0;
        b      = mbank;
        full0  = (mq.size() == LDQ);
        empty0 = (mq.size() == 0);
        if (rst) begin
            mq.delete(); mbank = 0; movf = 1'b0; merr = 1'b0;
            return;
        end
        if (ma_we) begin
            if (empty0) merr = 1'b1;
            else begin
                k = mq.pop_front();
                mreg[k] = ma_data;
            end
        end
        if (ex_we && !stall) mreg[key(ex_idx, b)] = ex_data;
        if (ld_issue && !stall) begin
            if (full0) merr = 1'b1;
            else       mq.push_back(key(ld_idx, b));
        end
        if (!stall && bank_push && !bank_pop) begin
            if (b == NBANK - 1) movf = 1'b1;
            else                mbank = b + 1;
        end
        if (!stall && bank_pop && !bank_push && b > 0) mbank = b - 1;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rd_idx = '0;
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset, then EX write of R3 read back next cycle
        rst = 1; cycle(); idle();
        ex_we = 1; ex_idx = 4'd3; ex_data = 32'h1234; cycle(); idle();
        rd_idx[3:0] = 4'd3; #1;
        check("r3_readback", rd_data[31:0], 32'h1234);
        check("r3_busy", {31'b0, busy[0]}, 32'd0);
        check("r3_bank", {31'b0, bank_cur}, 32'd0);
        cycle();

        // Give every physical register a known value: bank0 + shared, then bank1
        for (int i = 0; i < 16; i++) begin
            ex_we = 1; ex_idx = 4'(i); ex_data = 32'h1000 + 32'(i); cycle();
        end
        idle(); bank_push = 1; cycle(); idle();
        for (int i = 0; i < 8; i++) begin
            ex_we = 1; ex_idx = 4'(i); ex_data = 32'h2000 + 32'(i); cycle();
        end
        idle(); bank_pop = 1; cycle(); idle();

        // Load into bank0 R2 completes after a bank switch
        ld_issue = 1; ld_idx = 4'd2; cycle(); idle();
        bank_push = 1; cycle(); idle();
        cycle();
        ma_we = 1; ma_data = 32'hCAFE; cycle(); idle();
        rd_idx[3:0] = 4'd2; rd_idx[7:4] = 4'd2; #1;
        check("bank1_r2_unchanged", rd_data[31:0], 32'h2002);
        check("bank1_r2_busy", {31'b0, busy[0]}, 32'd0);
        bank_pop = 1; cycle(); idle(); #1;
        check("bank0_r2_load", rd_data[31:0], 32'hCAFE);
        check("bank0_r2_busy", {31'b0, busy[0]}, 32'd0);

        // EX and MA hit R5 in the same cycle: EX wins, queue drains
        ld_issue = 1; ld_idx = 4'd5; cycle(); idle();
        ex_we = 1; ex_idx = 4'd5; ex_data = 32'h11; ma_we = 1; ma_data = 32'h22;
        rd_idx[3:0] = 4'd5; cycle(); idle(); #1;
        check("r5_ex_wins", rd_data[31:0], 32'h11);
        check("r5_busy", {31'b0, busy[0]}, 32'd0);
        check("r5_qempty", {31'b0, ldq_full}, 32'd0);
        check("r5_no_err", {31'b0, ld_err}, 32'd0);

        // Read R1 during its load return
        ld_issue = 1; ld_idx = 4'd1; rd_idx[3:0] = 4'd1; cycle(); idle();
        ma_we = 1; ma_data = 32'hBEEF; #1;
`ifdef RF_BYPASS_EN
        check("r1_bypass_data", rd_data[31:0], 32'hBEEF);
        check("r1_bypass_busy", {31'b0, busy[0]}, 32'd0);
`else
        check("r1_old_data", rd_data[31:0], 32'h1001);
        check("r1_still_busy", {31'b0, busy[0]}, 32'd1);
`endif
        cycle(); idle();

        // Queue overflow: third back-to-back issue is dropped
        ld_issue = 1; ld_idx = 4'd1; cycle();
        ld_idx = 4'd2; cycle();
        ld_idx = 4'd3; cycle(); idle(); #1;
        check("ovf_full", {31'b0, ldq_full}, 32'd1);
        check("ovf_err", {31'b0, ld_err}, 32'd1);
        ma_we = 1; ma_data = 32'h5151; cycle(); ma_data = 32'h5252; cycle(); idle();
        rst = 1; cycle(); idle(); #1;
        check("err_cleared", {31'b0, ld_err}, 32'd0);

        // Bank stack saturation at the top, pops back to 0
        bank_push = 1; cycle(); cycle(); idle(); #1;
        check("push2_bank", {31'b0, bank_cur}, 32'd1);
        check("push2_ovf", {31'b0, bank_ovf}, 32'd1);
        bank_pop = 1; cycle(); cycle(); idle(); #1;
        check("pop2_bank", {31'b0, bank_cur}, 32'd0);

        // Reset discards an in-flight load; the late return is an error
        rst = 1; cycle(); idle();
        ld_issue = 1; ld_idx = 4'd9; cycle(); idle();
        rst = 1; cycle(); idle();
        ma_we = 1; ma_data = 32'h7777; cycle(); idle(); #1;
        check("late_return_err", {31'b0, ld_err}, 32'd1);
        rst = 1; cycle(); idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            ex_we     = 1'($urandom());
            ex_idx    = 4'($urandom());
            ex_data   = $urandom();
            ld_issue  = ($urandom_range(0, 2) == 0);
            ld_idx    = 4'($urandom());
            ma_we     = ($urandom_range(0, 2) == 0);
            ma_data   = $urandom();
            bank_push = ($urandom_range(0, 9) == 0);
            bank_pop  = ($urandom_range(0, 9) == 0);
            rd_idx    = (4*NRD)'($urandom());
            cycle();
        end
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
